// File: rtl/prbs_checker.sv
// -----------------------------------------------------------------------------
// prbs_checker
//
// Bit-serial PRBS checker. A local LFSR (chk) is first loaded straight from the
// received stream (SEED), then self-synchronises by comparing each received
// bit against the LFSR prediction while still shifting the received bit in
// (SYNC). After LOCK_CNT consecutive matches it declares lock and free-runs
// (LOCKED), shifting in its own prediction so a single flipped bit is counted
// exactly once. Too many errors inside one WINDOW-bit window drop lock and
// restart seeding.
//
// Ports:
//   i_clock      clock
//   i_reset      asynchronous, active-high reset
//   i_enable     block enable; when low all state is frozen
//   i_valid      qualifies i_bit
//   i_bit        received PRBS bit (generator's newly inserted LSB)
//   i_clear      synchronous clear of o_err_count (wins over an increment)
//   o_lock       registered lock indicator
//   o_error      one-cycle pulse per bit error detected while locked
//   o_err_count  saturating total error count since reset/clear
// -----------------------------------------------------------------------------
module prbs_checker #(
  parameter int N_BITS     = 12,
  parameter int EXP1       = 10,
  parameter int EXP2       = 9,
  parameter int LOCK_CNT   = 16,
  parameter int WINDOW     = 64,
  parameter int UNLOCK_ERR = 4,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic                 i_valid,
  input  logic                 i_bit,
  input  logic                 i_clear,
  output logic                 o_lock,
  output logic                 o_error,
  output logic [ERR_CNT_W-1:0] o_err_count
);

  localparam int SEED_W  = $clog2(N_BITS + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int WERR_W  = $clog2(UNLOCK_ERR + 1);

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [N_BITS-1:0]    chk_q, chk_d;
  logic [SEED_W-1:0]    seed_cnt_q, seed_cnt_d;
  logic [MATCH_W-1:0]   match_cnt_q, match_cnt_d;
  logic [WIN_W-1:0]     win_cnt_q, win_cnt_d;
  logic [WERR_W-1:0]    win_err_q, win_err_d;
  logic                 lock_q, lock_d;
  logic                 error_q, error_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic              vbit;
  logic              expected;
  logic              mismatch;
  logic [WERR_W:0]   err_sum;

  assign vbit     = i_enable & i_valid;
  assign expected = chk_q[EXP1] ^ chk_q[EXP2];
  assign mismatch = i_bit ^ expected;
  // One extra bit so win_err + mismatch cannot wrap before the threshold test.
  assign err_sum  = {1'b0, win_err_q} + {{WERR_W{1'b0}}, mismatch};

  always_comb begin
    state_d     = state_q;
    chk_d       = chk_q;
    seed_cnt_d  = seed_cnt_q;
    match_cnt_d = match_cnt_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    lock_d      = lock_q;
    error_d     = 1'b0;
    err_cnt_d   = err_cnt_q;

    if (vbit) begin
      unique case (state_q)
        ST_SEED: begin
          chk_d = {chk_q[N_BITS-2:0], i_bit};
          if (seed_cnt_q == SEED_W'(N_BITS - 1)) begin
            state_d     = ST_SYNC;
            seed_cnt_d  = '0;
            match_cnt_d = '0;
          end else begin
            seed_cnt_d = seed_cnt_q + SEED_W'(1);
          end
        end

        ST_SYNC: begin
          chk_d = {chk_q[N_BITS-2:0], i_bit};
          // An all-zero register predicts zeros forever; never count that
          // as progress toward lock.
          if (mismatch || (chk_q == '0)) begin
            match_cnt_d = '0;
          end else begin
            match_cnt_d = match_cnt_q + MATCH_W'(1);
            if (match_cnt_q == MATCH_W'(LOCK_CNT - 1)) begin
              state_d   = ST_LOCKED;
              lock_d    = 1'b1;
              win_cnt_d = '0;
              win_err_d = '0;
            end
          end
        end

        ST_LOCKED: begin
          // Free-run on the prediction so a flipped bit does not corrupt
          // the following predictions.
          chk_d   = {chk_q[N_BITS-2:0], expected};
          error_d = mismatch;
          if (mismatch && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
          end
          if (err_sum >= (WERR_W + 1)'(UNLOCK_ERR)) begin
            state_d    = ST_SEED;
            lock_d     = 1'b0;
            seed_cnt_d = '0;
            win_cnt_d  = '0;
            win_err_d  = '0;
          end else if (win_cnt_q == WIN_W'(WINDOW - 1)) begin
            // This bit's error was already judged against the closing window.
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
            win_err_d = err_sum[WERR_W-1:0];
          end
        end

        default: begin
          state_d = ST_SEED;
          lock_d  = 1'b0;
        end
      endcase
    end

    if (i_clear) begin
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_SEED;
      chk_q       <= '0;
      seed_cnt_q  <= '0;
      match_cnt_q <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      lock_q      <= 1'b0;
      error_q     <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      chk_q       <= chk_d;
      seed_cnt_q  <= seed_cnt_d;
      match_cnt_q <= match_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      lock_q      <= lock_d;
      error_q     <= error_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign o_lock      = lock_q;
  assign o_error     = error_q;
  assign o_err_count = err_cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// -----------------------------------------------------------------------------
// tb_prbs_checker
//
// Drives a 12-bit PRBS generator stream (seed 12'hABC, taps 10/9) into the
// checker. Stimulus pushes the expected output events (error pulses, lock
// rise/fall) tagged with the valid-bit index at which they must appear and
// the error count expected at that moment; a monitor pops and compares them
// whenever the DUT produces such an event.
// -----------------------------------------------------------------------------
module tb_prbs_checker;

  localparam logic [1:0] EV_ERR = 2'd0;
  localparam logic [1:0] EV_UP  = 2'd1;
  localparam logic [1:0] EV_DN  = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    int          idx;
    logic [15:0] cnt;
  } evt_t;

  logic        clk;
  logic        i_reset;
  logic        i_enable;
  logic        i_valid;
  logic        i_bit;
  logic        i_clear;
  logic        o_lock;
  logic        o_error;
  logic [15:0] o_err_count;

  evt_t        exp_q[$];
  int          checks;
  int          errors;
  int          vb;
  int          mon_vb;
  logic [11:0] g;

  prbs_checker dut (
    .i_clock     (clk),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
    .i_valid     (i_valid),
    .i_bit       (i_bit),
    .i_clear     (i_clear),
    .o_lock      (o_lock),
    .o_error     (o_error),
    .o_err_count (o_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1);
  end

  // Direct comparison.
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic expect_evt(input logic [1:0] k, input int idx, input int cnt);
    evt_t e;
    e.kind = k;
    e.idx  = idx;
    e.cnt  = 16'(cnt);
    exp_q.push_back(e);
  endtask

  // Monitor: pops the scoreboard whenever the DUT produces an event.
  task automatic got_evt(input logic [1:0] k);
    evt_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d at vbit %0d cnt=%0d, want no event",
               k, mon_vb, o_err_count);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== k || e.idx != mon_vb || e.cnt !== o_err_count) begin
        errors++;
        $display("FAIL event: got kind=%0d vbit=%0d cnt=%0d, want kind=%0d vbit=%0d cnt=%0d",
                 k, mon_vb, o_err_count, e.kind, e.idx, e.cnt);
      end
    end
  endtask

  initial begin
    bit v;
    bit prev_lock;
    mon_vb    = 0;
    prev_lock = 1'b0;
    forever begin
      @(posedge clk);
      v = (i_enable === 1'b1) && (i_valid === 1'b1) && (i_reset === 1'b0);
      #1;
      if (v) mon_vb++;
      if (o_error === 1'b1) got_evt(EV_ERR);
      if (o_lock === 1'b1 && !prev_lock) got_evt(EV_UP);
      if (o_lock !== 1'b1 && prev_lock) got_evt(EV_DN);
      prev_lock = (o_lock === 1'b1);
    end
  end

  // One stimulus cycle; the generator advances only on a consumed bit.
  task automatic send(input bit flip, input bit v, input bit en, input bit clr);
    logic b;
    b = 1'b0;
    if (v && en) begin
      b = g[10] ^ g[9];
      g = {g[10:0], b};
      b = b ^ flip;
    end
    @(negedge clk);
    i_bit    = b;
    i_valid  = v;
    i_enable = en;
    i_clear  = clr;
    if (v && en) vb++;
  endtask

  task automatic send_raw(input logic b);
    @(negedge clk);
    i_bit    = b;
    i_valid  = 1'b1;
    i_enable = 1'b1;
    i_clear  = 1'b0;
    vb++;
  endtask

  task automatic clean(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic clean_to(input int idx);
    clean(idx - vb);
  endtask

  task automatic err_at(input int idx, input int cnt);
    clean_to(idx - 1);
    expect_evt(EV_ERR, idx, cnt);
    send(1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic settle();
    send(1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_reset = 1'b1;
    i_valid = 1'b0;
    i_clear = 1'b0;
    repeat (2) @(negedge clk);
    i_reset = 1'b0;
  endtask

  initial begin
    int base;
    int cyc;
    checks   = 0;
    errors   = 0;
    vb       = 0;
    g        = 12'hABC;
    i_reset  = 1'b1;
    i_enable = 1'b0;
    i_valid  = 1'b0;
    i_bit    = 1'b0;
    i_clear  = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_lock",  int'(o_lock),      0);
    chk("reset_error", int'(o_error),     0);
    chk("reset_count", int'(o_err_count), 0);
    i_reset = 1'b0;

    // 1: clean stream locks after 12 + 16 valid bits, no errors.
    expect_evt(EV_UP, vb + 28, 0);
    clean(1000);
    settle();
    chk("t1_lock",  int'(o_lock),      1);
    chk("t1_count", int'(o_err_count), 0);

    // 2: a single flipped bit counts once.
    err_at(1010, 1);
    clean_to(1100);
    settle();
    chk("t2_lock",  int'(o_lock),      1);
    chk("t2_count", int'(o_err_count), 1);
    send(1'b0, 1'b0, 1'b1, 1'b1);
    settle();
    chk("clear_idle", int'(o_err_count), 0);

    // 3: four errors inside window 1117..1180 drop lock; relock 28 bits on.
    err_at(1120, 1);
    err_at(1130, 2);
    err_at(1140, 3);
    clean_to(1149);
    expect_evt(EV_ERR, 1150, 4);
    expect_evt(EV_DN,  1150, 4);
    send(1'b1, 1'b1, 1'b1, 1'b0);
    expect_evt(EV_UP, 1178, 4);
    clean_to(1200);
    settle();
    chk("t3_relock", int'(o_lock),      1);
    chk("t3_count",  int'(o_err_count), 4);
    send(1'b0, 1'b0, 1'b1, 1'b1);
    settle();
    chk("clear_idle2", int'(o_err_count), 0);

    // 4: windows after relock at 1178 are 1179+64k; 1306 closes one window.
    err_at(1250, 1);
    err_at(1280, 2);
    err_at(1306, 3);
    err_at(1310, 4);
    err_at(1330, 5);
    err_at(1360, 6);
    clean_to(1400);
    settle();
    chk("t4_lock",  int'(o_lock),      1);
    chk("t4_count", int'(o_err_count), 6);

    // 5a: all-zero stream never locks.
    expect_evt(EV_DN, vb, 0);
    do_reset();
    for (int i = 0; i < 500; i++) send_raw(1'b0);
    settle();
    chk("t5_zero_lock",  int'(o_lock),      0);
    chk("t5_zero_count", int'(o_err_count), 0);

    // 5b: random valid gaps and enable holds; lock still after 28 valid bits.
    do_reset();
    g    = 12'hABC;
    base = vb;
    expect_evt(EV_UP, base + 28, 0);
    cyc = 0;
    while (vb < base + 200 && cyc < 5000) begin
      send(1'b0, ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) != 0), 1'b0);
      cyc++;
    end
    settle();
    chk("t5_gap_lock",  int'(o_lock),      1);
    chk("t5_gap_count", int'(o_err_count), 0);

    // 6: five spread errors, then reset clears lock and count at once.
    err_at(base + 250, 1);
    err_at(base + 320, 2);
    err_at(base + 390, 3);
    err_at(base + 460, 4);
    err_at(base + 530, 5);
    clean_to(base + 560);
    settle();
    chk("t6_count5", int'(o_err_count), 5);
    chk("t6_lock",   int'(o_lock),      1);
    expect_evt(EV_DN, vb, 0);
    @(negedge clk);
    i_reset = 1'b1;
    #1;
    chk("t6_rst_lock",  int'(o_lock),      0);
    chk("t6_rst_count", int'(o_err_count), 0);
    @(negedge clk);
    i_reset = 1'b0;
    g = 12'hABC;
    expect_evt(EV_UP, vb + 28, 0);
    clean(40);
    // Clear in the same cycle as an error: count stays 0, pulse still seen.
    expect_evt(EV_ERR, vb + 1, 0);
    send(1'b1, 1'b1, 1'b1, 1'b1);
    clean(5);
    settle();
    chk("t6_clear_err", int'(o_err_count), 0);
    err_at(vb + 10, 1);
    clean(5);
    settle();
    chk("t6_after", int'(o_err_count), 1);

    repeat (5) @(negedge clk);
    chk("events_pending", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
